// File: rtl/id_issue_pkg.sv
// id_issue_pkg: shared codes, widths and the instruction decoder for the
// decode/issue stage. Covers the logic-immediate and logic-register subset.
package id_issue_pkg;

    localparam int INST_W  = 32;
    localparam int REG_W   = 32;
    localparam int RADDR_W = 5;

    localparam logic [REG_W-1:0] ZeroWord  = '0;
    localparam logic             RstEnable = 1'b1;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [7:0] {
        ALU_NOP = 8'h00,
        ALU_AND = 8'h24,
        ALU_OR  = 8'h25,
        ALU_XOR = 8'h26,
        ALU_NOR = 8'h27
    } aluop_e;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'b000,
        SEL_LOGIC = 3'b001
    } alusel_e;

    typedef struct packed {
        logic               re1;
        logic               re2;
        logic [RADDR_W-1:0] ra1;
        logic [RADDR_W-1:0] ra2;
        aluop_e             aluop;
        alusel_e            alusel;
        logic [REG_W-1:0]   imm;
        logic [RADDR_W-1:0] wd;
        logic               wreg;
        logic               illegal;
    } dec_t;

    function automatic dec_t decode(input logic [INST_W-1:0] inst);
        dec_t        d;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        d   = '0;
        op  = inst[31:26];
        rs  = inst[25:21];
        rt  = inst[20:16];
        rd  = inst[15:11];
        fn  = inst[5:0];
        imm = inst[15:0];
        unique case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                d.re1    = 1'b1;
                d.ra1    = rs;
                d.imm    = {16'h0, imm};
                d.wd     = rt;
                d.wreg   = 1'b1;
                d.alusel = SEL_LOGIC;
                if (op == OP_ANDI)
                    d.aluop = ALU_AND;
                else if (op == OP_XORI)
                    d.aluop = ALU_XOR;
                else
                    d.aluop = ALU_OR;
            end
            OP_LUI: begin
                // OR against a zero first operand places imm in the upper half
                d.imm    = {imm, 16'h0};
                d.wd     = rt;
                d.wreg   = 1'b1;
                d.alusel = SEL_LOGIC;
                d.aluop  = ALU_OR;
            end
            OP_SPECIAL: begin
                unique case (fn)
                    FN_AND:  d.aluop = ALU_AND;
                    FN_OR:   d.aluop = ALU_OR;
                    FN_XOR:  d.aluop = ALU_XOR;
                    FN_NOR:  d.aluop = ALU_NOR;
                    default: d.illegal = 1'b1;
                endcase
                if (!d.illegal) begin
                    d.re1    = 1'b1;
                    d.re2    = 1'b1;
                    d.ra1    = rs;
                    d.ra2    = rt;
                    d.wd     = rd;
                    d.wreg   = 1'b1;
                    d.alusel = SEL_LOGIC;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        // $0 is hardwired: never written, never tracked
        if (d.wd == '0)
            d.wreg = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: 32-entry pending-write vector for the issue stage.
// Ports: set_* (issue), clr_* (writeback), chk1/chk2/chkd lookups -> busy*.
module id_scoreboard
    import id_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en_i,
    input  logic [RADDR_W-1:0] set_addr_i,
    input  logic               clr_en_i,
    input  logic [RADDR_W-1:0] clr_addr_i,
    input  logic               chk1_en_i,
    input  logic [RADDR_W-1:0] chk1_addr_i,
    input  logic               chk2_en_i,
    input  logic [RADDR_W-1:0] chk2_addr_i,
    input  logic               chkd_en_i,
    input  logic [RADDR_W-1:0] chkd_addr_i,
    output logic               busy1_o,
    output logic               busy2_o,
    output logic               busyd_o
);

    logic [31:0] pend_q;
    logic [31:0] pend_d;

    // A writeback to the same register this cycle resolves the hazard:
    // the regfile bypasses the write data onto its read port.
    assign busy1_o = chk1_en_i && (chk1_addr_i != '0) && pend_q[chk1_addr_i]
                     && !(clr_en_i && (clr_addr_i == chk1_addr_i));
    assign busy2_o = chk2_en_i && (chk2_addr_i != '0) && pend_q[chk2_addr_i]
                     && !(clr_en_i && (clr_addr_i == chk2_addr_i));
    assign busyd_o = chkd_en_i && (chkd_addr_i != '0) && pend_q[chkd_addr_i]
                     && !(clr_en_i && (clr_addr_i == chkd_addr_i));

    // Set is applied after clear so a new writer keeps its bit.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i && (clr_addr_i != '0))
            pend_d[clr_addr_i] = 1'b0;
        if (set_en_i && (set_addr_i != '0))
            pend_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

endmodule

// File: rtl/id_issue.sv
// id_issue: decode/issue stage in front of the 32x32 regfile; drives the two
// read ports, stalls on RAW/WAW via id_scoreboard, and holds a one-entry slot
// for EX (ex_*). Handshakes: in_valid/in_ready upstream, ex_valid/ex_ready
// downstream; wb_* clears pending bits. Define ID_FWD_EN for fwd_* bypass.
module id_issue
    import id_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INST_W-1:0]  in_inst,
    output logic               in_ready,
    output logic               re1,
    output logic [RADDR_W-1:0] raddr1,
    input  logic [REG_W-1:0]   rdata1,
    output logic               re2,
    output logic [RADDR_W-1:0] raddr2,
    input  logic [REG_W-1:0]   rdata2,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_waddr,
`ifdef ID_FWD_EN
    input  logic               fwd_we,
    input  logic [RADDR_W-1:0] fwd_waddr,
    input  logic [REG_W-1:0]   fwd_wdata,
`endif
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [7:0]         ex_aluop,
    output logic [2:0]         ex_alusel,
    output logic [REG_W-1:0]   ex_reg1,
    output logic [REG_W-1:0]   ex_reg2,
    output logic [RADDR_W-1:0] ex_wd,
    output logic               ex_wreg,
    output logic               ex_illegal
);

    dec_t               dec;
    logic               busy1;
    logic               busy2;
    logic               busyd;
    logic               fwd1;
    logic               fwd2;
    logic [REG_W-1:0]   src1;
    logic [REG_W-1:0]   src2;
    logic               hazard;
    logic               accept;
    logic [REG_W-1:0]   op1_d;
    logic [REG_W-1:0]   op2_d;

    logic               ex_valid_q;
    logic [7:0]         aluop_q;
    logic [2:0]         alusel_q;
    logic [REG_W-1:0]   reg1_q;
    logic [REG_W-1:0]   reg2_q;
    logic [RADDR_W-1:0] wd_q;
    logic               wreg_q;
    logic               illegal_q;

    assign dec = decode(in_inst);

    assign re1    = in_valid & dec.re1;
    assign re2    = in_valid & dec.re2;
    assign raddr1 = in_valid ? dec.ra1 : '0;
    assign raddr2 = in_valid ? dec.ra2 : '0;

`ifdef ID_FWD_EN
    // EX result beats the regfile/wb bypass; it resolves RAW only, not WAW.
    assign fwd1 = fwd_we && re1 && (raddr1 != '0) && (fwd_waddr == raddr1);
    assign fwd2 = fwd_we && re2 && (raddr2 != '0) && (fwd_waddr == raddr2);
    assign src1 = fwd1 ? fwd_wdata : rdata1;
    assign src2 = fwd2 ? fwd_wdata : rdata2;
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
    assign src1 = rdata1;
    assign src2 = rdata2;
`endif

    id_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (accept & dec.wreg),
        .set_addr_i  (dec.wd),
        .clr_en_i    (wb_we),
        .clr_addr_i  (wb_waddr),
        .chk1_en_i   (re1),
        .chk1_addr_i (raddr1),
        .chk2_en_i   (re2),
        .chk2_addr_i (raddr2),
        .chkd_en_i   (in_valid & dec.wreg),
        .chkd_addr_i (dec.wd),
        .busy1_o     (busy1),
        .busy2_o     (busy2),
        .busyd_o     (busyd)
    );

    assign hazard   = (busy1 & ~fwd1) | (busy2 & ~fwd2) | busyd;
    assign in_ready = ~hazard & (~ex_valid_q | ex_ready);
    assign accept   = in_valid & in_ready;

    assign op1_d = dec.re1 ? src1 : ZeroWord;
    assign op2_d = dec.re2 ? src2 : dec.imm;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            ex_valid_q <= 1'b0;
            aluop_q    <= '0;
            alusel_q   <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            aluop_q    <= dec.aluop;
            alusel_q   <= dec.alusel;
            reg1_q     <= op1_d;
            reg2_q     <= op2_d;
            wd_q       <= dec.wd;
            wreg_q     <= dec.wreg;
            illegal_q  <= dec.illegal;
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_aluop   = aluop_q;
    assign ex_alusel  = alusel_q;
    assign ex_reg1    = reg1_q;
    assign ex_reg2    = reg2_q;
    assign ex_wd      = wd_q;
    assign ex_wreg    = wreg_q;
    assign ex_illegal = illegal_q;

endmodule
